// File: rtl/axis_push_rr_arbiter.sv
// Round-robin arbiter sharing one AXIS FIFO push port among NUM_REQ producers.
// Each owner keeps the port for at most MAX_BURST beats, then ownership rotates.
module axis_push_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          may_push,
    output logic                          push,
    output logic [DATA_WIDTH-1:0]         data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e                  state_q,  state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         owner_q,  owner_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic                    push_q,   push_d;
    logic [DATA_WIDTH-1:0]   data_q,   data_d;
    logic                    busy_q,   busy_d;

    logic                    found;
    logic [ID_W-1:0]         pick;
    logic [ID_W-1:0]         cand;
    logic [ID_W-1:0]         next_ptr;
    logic                    owner_valid;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   owner_data;

    // First valid requester searching upward from rr_ptr with wrap
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Only the owner may be ready, gated combinationally by FIFO room
    always_comb begin
        req_ready = '0;
        if (state_q == ST_GRANT) begin
            req_ready[owner_q] = may_push;
        end
    end

    assign owner_valid = req_valid[owner_q];
    assign accept      = owner_valid & req_ready[owner_q];
    assign owner_data  = req_data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
    assign next_ptr    = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        push_d   = 1'b0;
        data_d   = data_q;
        case (state_q)
            ST_ARB: begin
                if (found) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    push_d = 1'b1;
                    data_d = owner_data;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(MAX_BURST)) begin
                        state_d  = ST_ARB;
                        rr_ptr_d = next_ptr;
                    end
                end else if (may_push && !owner_valid) begin
                    // Owner idle while the FIFO has room: give the port up
                    state_d  = ST_ARB;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = ST_ARB;
        endcase
        busy_d = (state_d == ST_GRANT);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            push_q   <= push_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign push     = push_q;
    assign data     = data_q;
    assign grant_id = owner_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_axis_push_rr_arbiter.sv
// Scoreboard bench for axis_push_rr_arbiter: producer queues drive requesters,
// a negedge monitor checks every push against expected order.
module tb_axis_push_rr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 8;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              may_push;
    logic              push;
    logic [DW-1:0]     data;
    logic [1:0]        grant_id;
    logic              busy;

    axis_push_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .may_push (may_push),
        .push     (push),
        .data     (data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] txq [NR][$];
    logic [31:0] expq [$];
    int          stamps [$];
    logic [NR-1:0] acc_m = '0;
    int unsigned acc_cnt [NR];
    int unsigned gen_seq [NR];
    int unsigned rx_seq [NR];
    bit          mp_next  = 1'b1;
    bit          gen_rand = 1'b0;
    bit          mon_rand = 1'b0;
    int          cyc = 0;
    int          n_push = 0;
    int          burst = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] tag(input int i, input int s);
        return {8'(i), 24'(s)};
    endfunction

    task automatic load(input int i, input int s0, input int n);
        for (int s = s0; s < s0 + n; s++) txq[i].push_back(tag(i, s));
    endtask

    task automatic expect_beats(input int i, input int s0, input int n);
        for (int s = s0; s < s0 + n; s++) expq.push_back(tag(i, s));
    endtask

    // Producer model: present queue head, hold it until accepted
    always @(negedge clk) acc_m = req_valid & req_ready;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            logic hold;
            logic v;
            hold = req_valid[i] && !acc_m[i];
            if (acc_m[i] && aresetn) begin
                acc_cnt[i]++;
                if (txq[i].size() > 0) void'(txq[i].pop_front());
            end
            v = (txq[i].size() > 0) && (hold || !gen_rand || ($urandom_range(3) != 0));
            req_valid[i] = v;
            req_data[i*DW +: DW] = v ? txq[i][0] : '0;
        end
        may_push = gen_rand ? ($urandom_range(3) != 0) : mp_next;
    end

    // Monitor: push scoreboard, single-ready and burst-length checks
    always @(negedge clk) begin
        if (aresetn) begin
            check("ready_at_most_one", 64'($countones(req_ready) <= 1), 64'(1));
            if (!busy) burst = 0;
            else if (|(req_valid & req_ready)) begin
                burst++;
                check("burst_le_max", 64'(burst <= MB), 64'(1));
            end
            if (push) begin
                stamps.push_back(cyc);
                n_push++;
                if (mon_rand) begin
                    int id;
                    id = int'(data[31:24]);
                    if (id >= NR) check("rand_id_range", 64'(id), 64'(0));
                    else begin
                        check("rand_in_order", 64'(data[23:0]), 64'(24'(rx_seq[id])));
                        check("rand_grant_id", 64'(grant_id), 64'(id));
                        rx_seq[id]++;
                    end
                end else if (expq.size() == 0) begin
                    check("unexpected_push", 64'(data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = expq.pop_front();
                    check("push_data", 64'(data), 64'(e));
                    check("push_grant_id", 64'(grant_id), 64'(e[31:24]));
                end
            end
        end
    end

    task automatic clear_all();
        for (int i = 0; i < NR; i++) begin
            txq[i].delete();
            acc_cnt[i] = 0;
        end
        expq.delete();
        stamps.delete();
        n_push = 0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_all();
        mp_next  = 1'b1;
        gen_rand = 1'b0;
        mon_rand = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        bit busy_tx;
        n = 0;
        do begin
            @(negedge clk);
            busy_tx = 1'b0;
            for (int i = 0; i < NR; i++) if (txq[i].size() > 0) busy_tx = 1'b1;
            n++;
        end while ((expq.size() > 0 || busy_tx) && n < budget);
        if (n >= budget) check({name, "_drain_timeout"}, 64'(expq.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        aresetn   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        may_push  = 1'b1;
        do_reset();
        #1;
        check("rst_push", 64'(push), 64'(0));
        check("rst_data", 64'(data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));

        // T1: single requester, bursts 8/8/4 with one bubble per rotation
        load(2, 0, 20);
        expect_beats(2, 0, 20);
        wait_drain("t1", 200);
        check("t1_push_count", 64'(n_push), 64'(20));
        if (stamps.size() == 20)
            check("t1_push_span", 64'(stamps[19] - stamps[0]), 64'(21));
        else
            check("t1_stamp_count", 64'(stamps.size()), 64'(20));

        // T2: all four valid, two rounds of 8-beat bursts in order 0,1,2,3
        do_reset();
        for (int i = 0; i < NR; i++) load(i, 0, 16);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) expect_beats(i, r * 8, 8);
        wait_drain("t2", 400);
        check("t2_push_count", 64'(n_push), 64'(64));

        // T3: may_push stall after beat 3 of requester 1
        do_reset();
        load(1, 0, 8);
        expect_beats(1, 0, 8);
        n = 0;
        do begin @(negedge clk); n++; end while (acc_cnt[1] < 2 && n < 50);
        check("t3_reach_beat2", 64'(acc_cnt[1]), 64'(2));
        mp_next = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_stall_ready", 64'(req_ready), 64'(0));
            check("t3_stall_busy", 64'(busy), 64'(1));
            check("t3_stall_grant", 64'(grant_id), 64'(1));
            check("t3_stall_push", 64'(push), 64'(k == 0));
        end
        mp_next = 1'b1;
        wait_drain("t3", 100);
        check("t3_push_count", 64'(n_push), 64'(8));
        check("t3_released", 64'(busy), 64'(0));

        // T4: requester 3 idles after 2 beats, grant wraps to requester 0
        do_reset();
        load(3, 0, 2);
        expect_beats(3, 0, 2);
        n = 0;
        do begin @(negedge clk); n++; end while (!(busy && grant_id == 2'd3) && n < 50);
        check("t4_grant3", 64'(grant_id), 64'(3));
        load(0, 0, 4);
        load(1, 0, 4);
        expect_beats(0, 0, 4);
        expect_beats(1, 0, 4);
        wait_drain("t4", 100);
        check("t4_push_count", 64'(n_push), 64'(10));
        check("t4_last_owner", 64'(grant_id), 64'(1));

        // T5: reset in the middle of a burst of requester 2
        do_reset();
        load(2, 0, 8);
        expect_beats(2, 0, 3);
        n = 0;
        do begin @(negedge clk); n++; end while (acc_cnt[2] < 3 && n < 50);
        check("t5_reach_beat3", 64'(acc_cnt[2]), 64'(3));
        #2;
        aresetn = 1'b0;
        #1;
        check("t5_rst_push", 64'(push), 64'(0));
        check("t5_rst_busy", 64'(busy), 64'(0));
        check("t5_rst_grant", 64'(grant_id), 64'(0));
        clear_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        load(1, 0, 3);
        load(2, 100, 3);
        expect_beats(1, 0, 3);
        expect_beats(2, 100, 3);
        wait_drain("t5", 100);
        check("t5_push_count", 64'(n_push), 64'(6));

        // T6: random valid and may_push, per-requester in-order delivery
        do_reset();
        for (int i = 0; i < NR; i++) begin
            gen_seq[i] = 0;
            rx_seq[i]  = 0;
        end
        mon_rand = 1'b1;
        gen_rand = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if ($urandom_range(1) == 1) begin
                int r;
                r = int'($urandom_range(NR - 1));
                if (txq[r].size() < 16) begin
                    txq[r].push_back(tag(r, int'(gen_seq[r])));
                    gen_seq[r]++;
                end
            end
        end
        gen_rand = 1'b0;
        n = 0;
        do begin
            bit done;
            @(negedge clk);
            done = 1'b1;
            for (int i = 0; i < NR; i++) if (rx_seq[i] != gen_seq[i]) done = 1'b0;
            n++;
            if (done) break;
        end while (n < 2000);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NR; i++)
            check("t6_delivered_count", 64'(rx_seq[i]), 64'(gen_seq[i]));
        mon_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
